// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: bypass selects, divider-wait states,
// and the E-stage forwarding priority function.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // M beats W; $0 is hardwired so it never takes a bypass.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] wr_m,
        input logic       regwr_m,
        input logic [4:0] wr_w,
        input logic       regwr_w
    );
        if (src == 5'd0)                       return FWD_NONE;
        else if (regwr_m && (src == wr_m))     return FWD_MEM;
        else if (regwr_w && (src == wr_w))     return FWD_WB;
        else                                   return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the 5-stage datapath (master) and the hazard unit (slave).
interface hazard_unit_if;

    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoRegE, memtoRegM;
    logic       branchD, jrD;
    logic       div_startE, div_readyE;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, flushE;
    logic       div_busy, div_err;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM,
               branchD, jrD, div_startE, div_readyE,
        input  forwardAD, forwardBD, forwardAE, forwardBE,
               stallF, stallD, stallE, flushE, div_busy, div_err
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM,
               branchD, jrD, div_startE, div_readyE,
        output forwardAD, forwardBD, forwardAE, forwardBE,
               stallF, stallD, stallE, flushE, div_busy, div_err
    );

endinterface

// File: rtl/hazard_unit_div_stall_fsm.sv
// Freezes F/D/E while a multi-cycle divide is in flight, with a watchdog
// that gives up after DIV_TIMEOUT busy cycles and latches a sticky error.
module div_stall_fsm
    import hazard_unit_pkg::*;
#(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic div_start_i,
    input  logic div_ready_i,
    output logic divstall_o,
    output logic div_busy_o,
    output logic div_err_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             divstall, busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        divstall = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            DIV_IDLE: begin
                // A ready arriving with the start is ignored: divider latency is >=1.
                cnt_d = '0;
                if (div_start_i) begin
                    state_d  = DIV_BUSY;
                    divstall = 1'b1;
                end
            end
            DIV_BUSY: begin
                divstall = 1'b1;
                busy     = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (div_ready_i) begin
                    state_d = DIV_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DIV_DONE;
                    err_d   = 1'b1;
                end
            end
            // One release cycle so the still-held start does not re-trigger.
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    assign divstall_o = divstall & ~rst;
    assign div_busy_o = busy & ~rst;
    assign div_err_o  = err_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: bypass selects, load-use and branch-operand stalls,
// and the divider freeze, all combinational on the current stage contents.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
);

    logic lwstall, brstall, divstall, div_busy, div_err;
    logic hit_e, hit_m;

    div_stall_fsm #(
        .DIV_TIMEOUT (DIV_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_div_stall_fsm (
        .clk         (clk),
        .rst         (rst),
        .div_start_i (hz.div_startE),
        .div_ready_i (hz.div_readyE),
        .divstall_o  (divstall),
        .div_busy_o  (div_busy),
        .div_err_o   (div_err)
    );

    assign lwstall = hz.memtoRegE && (hz.rtE != 5'd0) &&
                     ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));

    // Branch/jr read operands in D, so an E result or an M load is not yet bypassable.
    assign hit_e   = hz.regwriteE && (hz.writeregE != 5'd0) &&
                     ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));
    assign hit_m   = hz.memtoRegM && (hz.writeregM != 5'd0) &&
                     ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD));
    assign brstall = (hz.branchD || hz.jrD) && (hit_e || hit_m);

    assign hz.forwardAE = rst ? FWD_NONE :
        fwd_sel(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    assign hz.forwardBE = rst ? FWD_NONE :
        fwd_sel(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);

    assign hz.forwardAD = ~rst && (hz.rsD != 5'd0) && (hz.rsD == hz.writeregM) && hz.regwriteM;
    assign hz.forwardBD = ~rst && (hz.rtD != 5'd0) && (hz.rtD == hz.writeregM) && hz.regwriteM;

    assign hz.stallF   = ~rst && (lwstall || brstall || divstall);
    assign hz.stallD   = ~rst && (lwstall || brstall || divstall);
    assign hz.stallE   = divstall;
    assign hz.flushE   = ~rst && (lwstall || brstall) && ~divstall;
    assign hz.div_busy = div_busy;
    assign hz.div_err  = div_err;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load/branch stalls, divider wait,
// watchdog timeout and reset abort.
module tb_hazard_unit;

    localparam int DIV_TIMEOUT = 64;
    localparam int CNT_W       = 7;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    hazard_unit_if hz_if ();

    hazard_unit #(
        .DIV_TIMEOUT (DIV_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz_if.rsD = '0;        hz_if.rtD = '0;
        hz_if.rsE = '0;        hz_if.rtE = '0;
        hz_if.writeregE = '0;  hz_if.writeregM = '0;  hz_if.writeregW = '0;
        hz_if.regwriteE = 1'b0; hz_if.regwriteM = 1'b0; hz_if.regwriteW = 1'b0;
        hz_if.memtoRegE = 1'b0; hz_if.memtoRegM = 1'b0;
        hz_if.branchD = 1'b0;  hz_if.jrD = 1'b0;
        hz_if.div_startE = 1'b0; hz_if.div_readyE = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        bit early_err;
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();

        // Reset with inputs that would otherwise forward and stall
        rst = 1'b1;
        hz_if.rsE = 5'd5; hz_if.rtE = 5'd5; hz_if.writeregM = 5'd5; hz_if.regwriteM = 1'b1;
        hz_if.rsD = 5'd5; hz_if.memtoRegE = 1'b1; hz_if.div_startE = 1'b1;
        @(negedge clk);
        check("rst_fwdAE", hz_if.forwardAE, 2'b00);
        check("rst_fwdBE", hz_if.forwardBE, 2'b00);
        check("rst_fwdAD", hz_if.forwardAD, 0);
        check("rst_stallF", hz_if.stallF, 0);
        check("rst_stallE", hz_if.stallE, 0);
        check("rst_flushE", hz_if.flushE, 0);
        check("rst_busy", hz_if.div_busy, 0);
        check("rst_err", hz_if.div_err, 0);
        tick();
        tick();
        rst = 1'b0;
        clear_inputs();

        // 1. E-stage forwarding priority and $0
        hz_if.rsE = 5'd5; hz_if.rtE = 5'd5;
        hz_if.writeregM = 5'd5; hz_if.regwriteM = 1'b1;
        hz_if.writeregW = 5'd5; hz_if.regwriteW = 1'b1;
        @(negedge clk);
        check("t1_fwdAE_mem", hz_if.forwardAE, 2'b10);
        check("t1_fwdBE_mem", hz_if.forwardBE, 2'b10);
        tick();
        hz_if.regwriteM = 1'b0;
        @(negedge clk);
        check("t1_fwdAE_wb", hz_if.forwardAE, 2'b01);
        check("t1_fwdBE_wb", hz_if.forwardBE, 2'b01);
        tick();
        hz_if.rsE = 5'd0;
        hz_if.writeregW = 5'd0;
        @(negedge clk);
        check("t1_fwdAE_r0", hz_if.forwardAE, 2'b00);
        tick();
        clear_inputs();
        hz_if.rsD = 5'd7; hz_if.writeregM = 5'd7; hz_if.regwriteM = 1'b1; hz_if.rtD = 5'd6;
        @(negedge clk);
        check("t1_fwdAD", hz_if.forwardAD, 1);
        check("t1_fwdBD", hz_if.forwardBD, 0);
        tick();
        clear_inputs();

        // 2. Load-use stall
        hz_if.memtoRegE = 1'b1; hz_if.rtE = 5'd8; hz_if.rsD = 5'd8;
        @(negedge clk);
        check("t2_stallF", hz_if.stallF, 1);
        check("t2_stallD", hz_if.stallD, 1);
        check("t2_flushE", hz_if.flushE, 1);
        check("t2_stallE", hz_if.stallE, 0);
        tick();
        hz_if.rtE = 5'd0;
        hz_if.rsD = 5'd0;
        @(negedge clk);
        check("t2_r0_stallF", hz_if.stallF, 0);
        check("t2_r0_flushE", hz_if.flushE, 0);
        tick();
        clear_inputs();

        // 3. Branch operand stalls
        hz_if.branchD = 1'b1; hz_if.rsD = 5'd3; hz_if.regwriteE = 1'b1; hz_if.writeregE = 5'd3;
        @(negedge clk);
        check("t3_e_stallF", hz_if.stallF, 1);
        check("t3_e_flushE", hz_if.flushE, 1);
        tick();
        hz_if.regwriteE = 1'b0; hz_if.writeregE = 5'd0;
        hz_if.memtoRegM = 1'b1; hz_if.writeregM = 5'd3;
        @(negedge clk);
        check("t3_m_stallF", hz_if.stallF, 1);
        check("t3_m_flushE", hz_if.flushE, 1);
        tick();
        hz_if.memtoRegM = 1'b0; hz_if.regwriteM = 1'b1;
        @(negedge clk);
        check("t3_alu_stallF", hz_if.stallF, 0);
        check("t3_alu_flushE", hz_if.flushE, 0);
        check("t3_alu_fwdAD", hz_if.forwardAD, 1);
        tick();
        clear_inputs();

        // 4. Divide with ready after 10 busy cycles; a load-use in D must not flush frozen E
        hz_if.div_startE = 1'b1; hz_if.rtE = 5'd8; hz_if.rsD = 5'd8;
        for (int c = 0; c < 12; c++) begin
            hz_if.div_readyE = (c == 10);
            hz_if.memtoRegE  = (c >= 2 && c <= 4);
            @(negedge clk);
            check($sformatf("t4_stallE_c%0d", c), hz_if.stallE, (c <= 10));
            check($sformatf("t4_stallF_c%0d", c), hz_if.stallF, (c <= 10));
            check($sformatf("t4_busy_c%0d", c), hz_if.div_busy, (c >= 1 && c <= 10));
            check($sformatf("t4_flushE_c%0d", c), hz_if.flushE, 0);
            tick();
        end
        hz_if.div_startE = 1'b0; hz_if.div_readyE = 1'b0;
        @(negedge clk);
        check("t4_idle_busy", hz_if.div_busy, 0);
        check("t4_idle_stallE", hz_if.stallE, 0);
        check("t4_no_err", hz_if.div_err, 0);
        tick();
        clear_inputs();

        // 5. Watchdog timeout
        hz_if.div_startE = 1'b1;
        busy_cnt  = 0;
        early_err = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (hz_if.div_busy) begin
                busy_cnt++;
                if (hz_if.div_err) early_err = 1'b1;
            end else if (busy_cnt > 0) begin
                break;
            end
            tick();
        end
        check("t5_busy_cycles", busy_cnt, DIV_TIMEOUT);
        check("t5_err_early", early_err, 0);
        check("t5_err_done", hz_if.div_err, 1);
        check("t5_done_stallE", hz_if.stallE, 0);
        tick();
        hz_if.div_startE = 1'b0;
        tick();
        @(negedge clk);
        check("t5_err_sticky", hz_if.div_err, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_err_cleared", hz_if.div_err, 0);
        tick();
        clear_inputs();

        // 6. Ready with start is ignored; reset aborts BUSY; late ready ignored
        hz_if.div_startE = 1'b1; hz_if.div_readyE = 1'b1;
        @(negedge clk);
        check("t6_start_stallE", hz_if.stallE, 1);
        tick();
        hz_if.div_readyE = 1'b0;
        @(negedge clk);
        check("t6_busy", hz_if.div_busy, 1);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", hz_if.div_busy, 0);
        check("t6_rst_stallE", hz_if.stallE, 0);
        check("t6_rst_stallF", hz_if.stallF, 0);
        tick();
        rst = 1'b0; hz_if.div_startE = 1'b0; hz_if.div_readyE = 1'b1;
        @(negedge clk);
        check("t6_post_busy", hz_if.div_busy, 0);
        check("t6_post_stallE", hz_if.stallE, 0);
        tick();
        hz_if.div_readyE = 1'b0;
        @(negedge clk);
        check("t6_late_busy", hz_if.div_busy, 0);
        check("t6_late_err", hz_if.div_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
